rr_priority_ctrl_l2: RTL and testbench

Parametrised round-robin priority-pointer generator for L2 crossbar arbiters. It supports any channel count, including non-power-of-two counts. It has two pointer-update modes: plain counter, or follow-last-grant. It also provides a burst lock and a per-channel starvation watchdog that forces priority to a starved master. One instance sits beside each L2 bank arbiter and drives that arbiter's priority flag.

---
 rtl/rr_priority_ctrl_l2.sv | 89 ++++++++
 tb/tb_rr_priority_ctrl_l2.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_priority_ctrl_l2.sv
// rtl/rr_priority_ctrl_l2.sv - round-robin priority pointer with burst lock and starvation override
module rr_priority_ctrl_l2 #(
  parameter int N_CH     = 8,
  parameter int WIDTH    = $clog2(N_CH),
  parameter int MODE     = 0,
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  req_i,
  input  logic             gnt_i,
  input  logic [WIDTH-1:0] gnt_idx_i,
  input  logic             lock_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] rr_flag_o,
  output logic             starve_o,
  output logic [WIDTH-1:0] starve_idx_o,
  output logic             advance_o
);

  localparam logic [WIDTH-1:0]  LAST     = WIDTH'(N_CH - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic              xfer;
  logic [WIDTH-1:0]  flag_next;
  logic [WAIT_W-1:0] wait_cnt  [N_CH];
  logic [WAIT_W-1:0] wait_next [N_CH];

  assign xfer = (|req_i) & gnt_i;

  // Scan from the top so the lowest starved index is the one left standing.
  always_comb begin
    starve_o     = 1'b0;
    starve_idx_o = '0;
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (wait_cnt[c] == WAIT_MAX) begin
        starve_o     = 1'b1;
        starve_idx_o = WIDTH'(c);
      end
    end
  end

  always_comb begin
    flag_next = rr_flag_o;
    if (flush_i) begin
      flag_next = '0;
    end else if (lock_i) begin
      flag_next = rr_flag_o;
    end else if (starve_o) begin
      flag_next = starve_idx_o;
    end else if (xfer) begin
      if (MODE == 0) begin
        flag_next = (rr_flag_o == LAST) ? '0 : rr_flag_o + WIDTH'(1);
      end else begin
        // Out-of-range indices fall into the >= branch and wrap to zero.
        flag_next = (gnt_idx_i >= LAST) ? '0 : gnt_idx_i + WIDTH'(1);
      end
    end
  end

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      wait_next[c] = wait_cnt[c];
      if (flush_i || !req_i[c] || (xfer && (gnt_idx_i == WIDTH'(c)))) begin
        wait_next[c] = '0;
      end else if (wait_cnt[c] != WAIT_MAX) begin
        wait_next[c] = wait_cnt[c] + WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_flag_o <= '0;
      advance_o <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        wait_cnt[c] <= '0;
      end
    end else begin
      rr_flag_o <= flag_next;
      advance_o <= (flag_next != rr_flag_o);
      for (int c = 0; c < N_CH; c++) begin
        wait_cnt[c] <= wait_next[c];
      end
    end
  end

endmodule

// File: tb/tb_rr_priority_ctrl_l2.sv
// tb/tb_rr_priority_ctrl_l2.sv - scoreboard bench for rr_priority_ctrl_l2 (counter and follow instances)
module tb_rr_priority_ctrl_l2;

  localparam int MW = 4;

  typedef struct {
    logic [2:0] ptr;
    logic       adv;
    logic       st;
    logic [2:0] sidx;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [4:0] a_req = '0;
  logic       a_gnt = 1'b0;
  logic [2:0] a_idx = '0;
  logic       a_lock = 1'b0;
  logic       a_flush = 1'b0;
  logic [2:0] a_flag;
  logic       a_starve;
  logic [2:0] a_sidx;
  logic       a_adv;

  logic [7:0] b_req = '0;
  logic       b_gnt = 1'b0;
  logic [2:0] b_idx = '0;
  logic       b_lock = 1'b0;
  logic       b_flush = 1'b0;
  logic [2:0] b_flag;
  logic       b_starve;
  logic [2:0] b_sidx;
  logic       b_adv;

  int checks = 0;
  int errors = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  int   m_ptr [2];
  int   m_wait [2][8];

  logic [2:0] wrap_seq [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};

  always #5 clk = ~clk;

  rr_priority_ctrl_l2 #(.N_CH(5), .MODE(0), .MAX_WAIT(MW)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_i(a_req), .gnt_i(a_gnt), .gnt_idx_i(a_idx),
    .lock_i(a_lock), .flush_i(a_flush), .rr_flag_o(a_flag), .starve_o(a_starve),
    .starve_idx_o(a_sidx), .advance_o(a_adv)
  );

  rr_priority_ctrl_l2 #(.N_CH(8), .MODE(1), .MAX_WAIT(MW)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_i(b_req), .gnt_i(b_gnt), .gnt_idx_i(b_idx),
    .lock_i(b_lock), .flush_i(b_flush), .rr_flag_o(b_flag), .starve_o(b_starve),
    .starve_idx_o(b_sidx), .advance_o(b_adv)
  );

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_ptr[u] = 0;
      for (int c = 0; c < 8; c++) m_wait[u][c] = 0;
    end
  endtask

  task automatic model_push(input int u, input int n, input int mode, input logic [7:0] req,
                            input logic gnt, input int idx, input logic lock, input logic flush);
    int   any;
    int   st;
    int   si;
    int   nx;
    exp_t e;
    any = 0;
    for (int c = 0; c < n; c++) if (req[c]) any = 1;
    st = 0;
    si = 0;
    for (int c = n - 1; c >= 0; c--) if (m_wait[u][c] == MW) begin st = 1; si = c; end
    if (flush) nx = 0;
    else if (lock) nx = m_ptr[u];
    else if (st != 0) nx = si;
    else if (any != 0 && gnt) begin
      if (mode == 0) nx = (m_ptr[u] == n - 1) ? 0 : m_ptr[u] + 1;
      else           nx = (idx >= n - 1) ? 0 : idx + 1;
    end else nx = m_ptr[u];
    e.adv = (nx != m_ptr[u]);
    m_ptr[u] = nx;
    for (int c = 0; c < n; c++) begin
      if (flush || !req[c] || (any != 0 && gnt && idx == c)) m_wait[u][c] = 0;
      else if (m_wait[u][c] < MW) m_wait[u][c] = m_wait[u][c] + 1;
    end
    st = 0;
    si = 0;
    for (int c = n - 1; c >= 0; c--) if (m_wait[u][c] == MW) begin st = 1; si = c; end
    e.ptr  = 3'(nx);
    e.st   = (st != 0);
    e.sidx = 3'(si);
    if (u == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  // Predict both instances from the inputs currently applied, then clock once.
  task automatic cycle();
    model_push(0, 5, 0, {3'b000, a_req}, a_gnt, int'(a_idx), a_lock, a_flush);
    model_push(1, 8, 1, b_req, b_gnt, int'(b_idx), b_lock, b_flush);
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    exp_t ea;
    exp_t eb;
    #1;
    if (q_a.size() > 0) begin
      ea = q_a.pop_front();
      checks += 4;
      if (a_flag !== ea.ptr)    begin errors++; $display("FAIL sb_a_flag actual=%0d required=%0d", a_flag, ea.ptr); end
      if (a_adv !== ea.adv)     begin errors++; $display("FAIL sb_a_adv actual=%0b required=%0b", a_adv, ea.adv); end
      if (a_starve !== ea.st)   begin errors++; $display("FAIL sb_a_starve actual=%0b required=%0b", a_starve, ea.st); end
      if (a_sidx !== ea.sidx)   begin errors++; $display("FAIL sb_a_sidx actual=%0d required=%0d", a_sidx, ea.sidx); end
    end
    if (q_b.size() > 0) begin
      eb = q_b.pop_front();
      checks += 4;
      if (b_flag !== eb.ptr)    begin errors++; $display("FAIL sb_b_flag actual=%0d required=%0d", b_flag, eb.ptr); end
      if (b_adv !== eb.adv)     begin errors++; $display("FAIL sb_b_adv actual=%0b required=%0b", b_adv, eb.adv); end
      if (b_starve !== eb.st)   begin errors++; $display("FAIL sb_b_starve actual=%0b required=%0b", b_starve, eb.st); end
      if (b_sidx !== eb.sidx)   begin errors++; $display("FAIL sb_b_sidx actual=%0d required=%0d", b_sidx, eb.sidx); end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    checks += 4;
    if (a_flag !== 3'd0 || a_adv !== 1'b0) begin errors++; $display("FAIL reset_a flag=%0d adv=%0b required 0 0", a_flag, a_adv); end
    if (a_starve !== 1'b0 || a_sidx !== 3'd0) begin errors++; $display("FAIL reset_a_starve st=%0b idx=%0d required 0 0", a_starve, a_sidx); end
    if (b_flag !== 3'd0 || b_adv !== 1'b0) begin errors++; $display("FAIL reset_b flag=%0d adv=%0b required 0 0", b_flag, b_adv); end
    if (b_starve !== 1'b0 || b_sidx !== 3'd0) begin errors++; $display("FAIL reset_b_starve st=%0b idx=%0d required 0 0", b_starve, b_sidx); end
  endtask

  task automatic test_counter_wrap();
    a_req = 5'b00001;
    a_gnt = 1'b1;
    a_idx = 3'd0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      checks += 2;
      if (a_flag !== wrap_seq[i]) begin errors++; $display("FAIL wrap_flag step=%0d actual=%0d required=%0d", i, a_flag, wrap_seq[i]); end
      if (a_adv !== 1'b1) begin errors++; $display("FAIL wrap_adv step=%0d actual=%0b required=1", i, a_adv); end
    end
    a_req = '0;
    a_gnt = 1'b0;
  endtask

  task automatic test_follow();
    b_req = 8'h08; b_gnt = 1'b1; b_idx = 3'd3;
    cycle();
    checks++;
    if (b_flag !== 3'd4) begin errors++; $display("FAIL follow_idx3 actual=%0d required=4", b_flag); end
    b_req = 8'h80; b_idx = 3'd7;
    cycle();
    checks++;
    if (b_flag !== 3'd0) begin errors++; $display("FAIL follow_idx7 actual=%0d required=0", b_flag); end
    b_req = 8'h04; b_idx = 3'd2; b_lock = 1'b1;
    cycle();
    checks += 2;
    if (b_flag !== 3'd0) begin errors++; $display("FAIL follow_lock_flag actual=%0d required=0", b_flag); end
    if (b_adv !== 1'b0) begin errors++; $display("FAIL follow_lock_adv actual=%0b required=0", b_adv); end
    b_req = '0; b_gnt = 1'b0; b_lock = 1'b0;
  endtask

  task automatic test_starve();
    b_req = 8'h42; b_gnt = 1'b1; b_idx = 3'd1;
    repeat (3) cycle();
    checks++;
    if (b_starve !== 1'b0) begin errors++; $display("FAIL starve_early actual=%0b required=0", b_starve); end
    cycle();
    checks += 2;
    if (b_starve !== 1'b1) begin errors++; $display("FAIL starve_assert actual=%0b required=1", b_starve); end
    if (b_sidx !== 3'd6) begin errors++; $display("FAIL starve_idx actual=%0d required=6", b_sidx); end
    cycle();
    checks++;
    if (b_flag !== 3'd6) begin errors++; $display("FAIL starve_force actual=%0d required=6", b_flag); end
    b_idx = 3'd6;
    cycle();
    checks++;
    if (b_starve !== 1'b0) begin errors++; $display("FAIL starve_clear actual=%0b required=0", b_starve); end
    b_req = '0; b_gnt = 1'b0;
  endtask

  task automatic test_lock_starve();
    b_req = 8'h08; b_gnt = 1'b0;
    repeat (4) cycle();
    checks++;
    if (b_starve !== 1'b1 || b_sidx !== 3'd3) begin errors++; $display("FAIL lock_setup st=%0b idx=%0d required 1 3", b_starve, b_sidx); end
    b_lock = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (b_flag !== 3'd6) begin errors++; $display("FAIL lock_hold step=%0d actual=%0d required=6", i, b_flag); end
    end
    b_lock = 1'b0;
    cycle();
    checks++;
    if (b_flag !== 3'd3) begin errors++; $display("FAIL lock_release actual=%0d required=3", b_flag); end
    b_req = '0;
    cycle();
  endtask

  task automatic test_multi_starve();
    b_req = 8'h24; b_gnt = 1'b0;
    repeat (4) cycle();
    checks++;
    if (b_starve !== 1'b1 || b_sidx !== 3'd2) begin errors++; $display("FAIL tie_lowest st=%0b idx=%0d required 1 2", b_starve, b_sidx); end
    b_gnt = 1'b1; b_idx = 3'd2;
    cycle();
    checks += 2;
    if (b_sidx !== 3'd5) begin errors++; $display("FAIL tie_next actual=%0d required=5", b_sidx); end
    if (b_flag !== 3'd2) begin errors++; $display("FAIL tie_force actual=%0d required=2", b_flag); end
    b_req = '0; b_gnt = 1'b0;
    cycle();
  endtask

  task automatic test_flush();
    b_req = 8'h06; b_gnt = 1'b1; b_idx = 3'd2;
    cycle();
    checks++;
    if (b_flag !== 3'd3) begin errors++; $display("FAIL flush_setup actual=%0d required=3", b_flag); end
    b_flush = 1'b1; b_lock = 1'b1;
    cycle();
    checks += 2;
    if (b_flag !== 3'd0 || b_starve !== 1'b0) begin errors++; $display("FAIL flush_clear flag=%0d st=%0b required 0 0", b_flag, b_starve); end
    if (b_adv !== 1'b1) begin errors++; $display("FAIL flush_adv actual=%0b required=1", b_adv); end
    cycle();
    checks++;
    if (b_adv !== 1'b0) begin errors++; $display("FAIL flush_zero_adv actual=%0b required=0", b_adv); end
    b_flush = 1'b0; b_lock = 1'b0; b_req = '0; b_gnt = 1'b0;
  endtask

  task automatic test_async_reset();
    a_req = 5'b00001; a_gnt = 1'b1; a_idx = 3'd0;
    b_req = 8'h02; b_gnt = 1'b1; b_idx = 3'd1;
    repeat (2) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (a_flag !== 3'd0 || a_adv !== 1'b0) begin errors++; $display("FAIL async_a flag=%0d adv=%0b required 0 0", a_flag, a_adv); end
    if (b_flag !== 3'd0 || b_adv !== 1'b0) begin errors++; $display("FAIL async_b flag=%0d adv=%0b required 0 0", b_flag, b_adv); end
    if (b_starve !== 1'b0) begin errors++; $display("FAIL async_starve actual=%0b required=0", b_starve); end
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cycle();
    checks++;
    if (a_flag !== 3'd1) begin errors++; $display("FAIL async_resume actual=%0d required=1", a_flag); end
    a_req = '0; a_gnt = 1'b0; b_req = '0; b_gnt = 1'b0;
    cycle();
  endtask

  initial begin
    test_reset();
    test_counter_wrap();
    test_follow();
    test_starve();
    test_lock_starve();
    test_multi_starve();
    test_flush();
    test_async_reset();
    @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
